alu_arbiter: RTL and testbench

// - Shares one combinational alu instance between NUM_REQ requesters, e.g. the issue stage and a CSR/debug path.
// - Round-robin arbitration, valid/ready on both request and response sides.
// - One operation in flight; the result is registered and held until consumed.
// - Back-to-back throughput is 1 op/cycle when rsp_ready stays high.

---
 rtl/lx32_alu_pkg.sv | 23 ++
 rtl/alu.sv | 41 ++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/lx32_alu_pkg.sv
// Shared ALU operation encoding plus the arbiter FSM state type.
// Imported by the alu, the round-robin picker and the arbiter top.
package lx32_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; zero latency, no flow control of its own.
// Shift amounts use the low log2(WIDTH) bits of src_b.
module alu
    import lx32_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;

    assign shamt = src_b[SHW-1:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SLL:  result = src_a << shamt;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $signed(src_a) >>> shamt;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Zero latency; gnt is all-zero when no request is present.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one alu across NUM_REQ requesters; result registered, 1-cycle latency.
// A held result blocks new grants until rsp_ready; consume and accept may share an edge.
module alu_arbiter
    import lx32_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_src_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_src_b,
    input  alu_op_e [NUM_REQ-1:0]           req_op,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [WIDTH-1:0]                rsp_result,
    output logic [ID_W-1:0]                 rsp_id
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_vld;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_result;
    alu_op_e            alu_op;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_vld    = |req_valid;
    assign can_accept = (state_q == ARB_IDLE) | ((state_q == ARB_HOLD) & rsp_ready);
    // Reset gating keeps a stale pointer from leaking a grant during the reset cycle.
    assign accept     = can_accept & any_vld & ~rst;
    assign req_ready  = accept ? gnt : '0;

    assign alu_a  = any_vld ? req_src_a[gnt_idx] : '0;
    assign alu_b  = any_vld ? req_src_b[gnt_idx] : '0;
    assign alu_op = any_vld ? req_op[gnt_idx]    : ALU_ADD;

    alu #(.WIDTH(WIDTH)) u_alu (
        .src_a  (alu_a),
        .src_b  (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        result_d = result_q;
        id_d     = id_q;
        if (accept) begin
            state_d  = ARB_HOLD;
            result_d = alu_result;
            id_d     = gnt_idx;
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if ((state_q == ARB_HOLD) && rsp_ready) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            result_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid  = (state_q == ARB_HOLD);
    assign rsp_result = result_q;
    assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed expected values.
module tb_alu_arbiter;
    import lx32_alu_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][31:0]     req_src_a;
    logic [1:0][31:0]     req_src_b;
    alu_op_e [1:0]        req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_result;
    logic [0:0]           rsp_id;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(32), .NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src_a  (req_src_a),
        .req_src_b  (req_src_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_op[r]    = op;
        req_src_a[r] = a;
        req_src_b[r] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        req_src_a = '0;
        req_src_b = '0;
        req_op    = {ALU_ADD, ALU_ADD};

        // Reset: no grant even with a valid request
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        tick();
        tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rr_ptr", dut.rr_ptr_q, 1'b0);

        // 1: single op req0 ADD 5+10
        rst = 1'b0;
        set_req(0, ALU_ADD, 32'd5, 32'd10);
        req_valid = 2'b01;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_result", rsp_result, 32'hF);
        chk("t1_rsp_id", rsp_id, 1'b0);
        req_valid = 2'b00;
        tick();
        chk("t1_idle_rsp_valid", rsp_valid, 1'b0);
        chk("t1_rr_ptr", dut.rr_ptr_q, 1'b1);

        // 2: both valid, rr_ptr=1 so grants go 1,0,1,0 with no bubbles
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        set_req(1, ALU_XOR, 32'hAAAAAAAA, 32'h55555555);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_res;
            logic        g;
            g       = (i % 2 == 0) ? 1'b1 : 1'b0;
            exp_res = g ? 32'hFFFFFFFF : 32'h7;
            #1;
            chk("t2_req_ready", req_ready, g ? 2'b10 : 2'b01);
            tick();
            chk("t2_rsp_valid", rsp_valid, 1'b1);
            chk("t2_rsp_id", rsp_id, g);
            chk("t2_rsp_result", rsp_result, exp_res);
        end
        req_valid = 2'b00;
        tick();
        chk("t2_idle", rsp_valid, 1'b0);

        // 3: SRA result held under backpressure for 3 cycles
        set_req(0, ALU_SRA, 32'h80000000, 32'd1);
        req_valid = 2'b01;
        #1;
        chk("t3_req_ready", req_ready, 2'b01);
        tick();
        chk("t3_rsp_result", rsp_result, 32'hC0000000);
        rsp_ready = 1'b0;
        set_req(1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_bp_req_ready", req_ready, 2'b00);
            tick();
            chk("t3_bp_rsp_valid", rsp_valid, 1'b1);
            chk("t3_bp_rsp_result", rsp_result, 32'hC0000000);
            chk("t3_bp_rsp_id", rsp_id, 1'b0);
        end

        // 4: consume and accept req1 SLT on the same edge
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        #1;
        chk("t4_req_ready", req_ready, 2'b10);
        tick();
        chk("t4_rsp_valid", rsp_valid, 1'b1);
        chk("t4_rsp_result", rsp_result, 32'h1);
        chk("t4_rsp_id", rsp_id, 1'b1);
        chk("t4_rr_ptr", dut.rr_ptr_q, 1'b0);

        // 5: fairness, req0 always valid, req1 raised once while rr_ptr=0
        set_req(0, ALU_ADD, 32'd5, 32'd10);
        set_req(1, ALU_ADD, 32'd1, 32'd2);
        req_valid = 2'b11;
        #1;
        chk("t5_gnt0_req_ready", req_ready, 2'b01);
        tick();
        chk("t5_gnt0_rsp_id", rsp_id, 1'b0);
        chk("t5_gnt0_rsp_result", rsp_result, 32'hF);
        #1;
        chk("t5_gnt1_req_ready", req_ready, 2'b10);
        tick();
        chk("t5_gnt1_rsp_id", rsp_id, 1'b1);
        chk("t5_gnt1_rsp_result", rsp_result, 32'h3);
        chk("t5_rr_ptr_wrap", dut.rr_ptr_q, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("t5_gnt2_req_ready", req_ready, 2'b01);
        tick();
        chk("t5_gnt2_rsp_id", rsp_id, 1'b0);

        // 6: reset while holding a result
        chk("t6_pre_rsp_valid", rsp_valid, 1'b1);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("t6_rst_req_ready", req_ready, 2'b00);
        tick();
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_rsp_result", rsp_result, 32'h0);
        chk("t6_rsp_id", rsp_id, 1'b0);
        chk("t6_rr_ptr", dut.rr_ptr_q, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_post_req_ready", req_ready, 2'b01);
        tick();
        chk("t6_post_rsp_id", rsp_id, 1'b0);
        chk("t6_post_rsp_result", rsp_result, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
